// File: rtl/transmisor_serial_multi.sv
// Multi-channel UART-style frame transmitter: N_CH words per frame, each framed as
// start / LSB-first data / optional even parity / stop, followed by an idle-high gap.
module transmisor_serial_multi #(
    parameter int N_CH         = 3,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 30000,
    parameter int PARITY_EN    = 0,
    parameter int AUTO_REPEAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic                   start,
    output logic                   canal_serial,
    output logic                   busy,
    output logic                   frame_done,
    output logic [13:0]            decimal
);
    localparam int CH_BITS    = DATA_W + 2 + PARITY_EN;
    localparam int FRAME_BITS = N_CH * CH_BITS;
    localparam int BIT_CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_CNT_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int IDX_W      = $clog2(DATA_W);
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DEC_W      = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_GAP
    } state_t;

    state_t                   r_state;
    logic [BIT_CNT_W-1:0]     r_bit_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [CH_W-1:0]          r_ch;
    logic [GAP_CNT_W-1:0]     r_gap;
    logic [DEC_W-1:0]         r_dec;
    logic [N_CH*DATA_W-1:0]   r_snap;
    logic                     r_line;
    logic                     r_busy;
    logic                     r_done;

    state_t                   w_state_nxt;
    logic [BIT_CNT_W-1:0]     w_bit_cnt_nxt;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [CH_W-1:0]          w_ch_nxt;
    logic [GAP_CNT_W-1:0]     w_gap_nxt;
    logic [DEC_W-1:0]         w_dec_nxt;
    logic [N_CH*DATA_W-1:0]   w_snap_nxt;
    logic                     w_line_nxt;
    logic                     w_busy_nxt;
    logic                     w_done_nxt;
    logic [DATA_W-1:0]        w_words [N_CH];
    logic [DATA_W-1:0]        w_word_nxt;
    logic                     w_bit_end;
    logic                     w_launch;

    assign w_bit_end = (r_bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
    assign w_launch  = (AUTO_REPEAT != 0) || start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_ch      <= '0;
            r_gap     <= '0;
            r_dec     <= '0;
            r_snap    <= '0;
            r_line    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_ch      <= w_ch_nxt;
            r_gap     <= w_gap_nxt;
            r_dec     <= w_dec_nxt;
            r_snap    <= w_snap_nxt;
            r_line    <= w_line_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_idx_nxt     = r_idx;
        w_ch_nxt      = r_ch;
        w_gap_nxt     = r_gap;
        w_dec_nxt     = r_dec;
        w_snap_nxt    = r_snap;

        // Bit-period counter and frame bit index advance together in every serial state.
        if (r_state inside {ST_START, ST_DATA, ST_PAR, ST_STOP}) begin
            w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + BIT_CNT_W'(1);
            if (w_bit_end) begin
                w_dec_nxt = r_dec + DEC_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt   = ST_START;
                    w_snap_nxt    = data_in;
                    w_ch_nxt      = '0;
                    w_bit_cnt_nxt = '0;
                    w_dec_nxt     = '0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_W'(DATA_W - 1)) begin
                        w_state_nxt = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_ch != CH_W'(N_CH - 1)) begin
                        w_state_nxt = ST_START;
                        w_ch_nxt    = r_ch + CH_W'(1);
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = '0;
                        w_dec_nxt   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                    w_gap_nxt = '0;
                    if (AUTO_REPEAT != 0) begin
                        w_state_nxt   = ST_START;
                        w_snap_nxt    = data_in;
                        w_ch_nxt      = '0;
                        w_bit_cnt_nxt = '0;
                        w_dec_nxt     = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap + GAP_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered line lines up with the state.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_words[i] = w_snap_nxt[i*DATA_W +: DATA_W];
        end
        w_word_nxt = w_words[w_ch_nxt];
        case (w_state_nxt)
            ST_START: w_line_nxt = 1'b0;
            ST_DATA:  w_line_nxt = w_word_nxt[w_idx_nxt];
            ST_PAR:   w_line_nxt = ^w_word_nxt;
            default:  w_line_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (r_state == ST_STOP) && (w_state_nxt == ST_GAP);
    end

    assign canal_serial = r_line;
    assign busy         = r_busy;
    assign frame_done   = r_done;
    assign decimal      = {{(14 - DEC_W){1'b0}}, r_dec};

endmodule

// File: tb/tb_transmisor_serial_multi.sv
// Bench for transmisor_serial_multi: four instances covering plain, slow-bit, parity
// and auto-repeat configurations, checked against a frame-level bit-list model.
module tb_transmisor_serial_multi;

    logic        clk;
    logic        rst_a, rst_bc, rst_d;
    logic        st_a, st_b, st_c, st_d;
    logic [23:0] din_a;
    logic [7:0]  din_b;
    logic [13:0] din_c;
    logic [23:0] din_d;
    logic        line_a, line_b, line_c, line_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic [13:0] dec_a, dec_b, dec_c, dec_d;

    int          sel;
    logic        o_line, o_busy, o_done;
    logic [13:0] o_dec;

    int          checks;
    int          failures;
    logic [0:0]  exp_q[$];
    logic [13:0] dec_q[$];

    transmisor_serial_multi #(.N_CH(3), .DATA_W(8), .CLKS_PER_BIT(1), .GAP_CYCLES(4),
                              .PARITY_EN(0), .AUTO_REPEAT(0)) dut_a (
        .clk(clk), .rst_n(rst_a), .data_in(din_a), .start(st_a),
        .canal_serial(line_a), .busy(busy_a), .frame_done(done_a), .decimal(dec_a));

    transmisor_serial_multi #(.N_CH(1), .DATA_W(8), .CLKS_PER_BIT(3), .GAP_CYCLES(2),
                              .PARITY_EN(0), .AUTO_REPEAT(0)) dut_b (
        .clk(clk), .rst_n(rst_bc), .data_in(din_b), .start(st_b),
        .canal_serial(line_b), .busy(busy_b), .frame_done(done_b), .decimal(dec_b));

    transmisor_serial_multi #(.N_CH(2), .DATA_W(7), .CLKS_PER_BIT(2), .GAP_CYCLES(3),
                              .PARITY_EN(1), .AUTO_REPEAT(0)) dut_c (
        .clk(clk), .rst_n(rst_bc), .data_in(din_c), .start(st_c),
        .canal_serial(line_c), .busy(busy_c), .frame_done(done_c), .decimal(dec_c));

    transmisor_serial_multi #(.N_CH(3), .DATA_W(8), .CLKS_PER_BIT(1), .GAP_CYCLES(4),
                              .PARITY_EN(0), .AUTO_REPEAT(1)) dut_d (
        .clk(clk), .rst_n(rst_d), .data_in(din_d), .start(st_d),
        .canal_serial(line_d), .busy(busy_d), .frame_done(done_d), .decimal(dec_d));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    always_comb begin
        case (sel)
            0: begin o_line = line_a; o_busy = busy_a; o_done = done_a; o_dec = dec_a; end
            1: begin o_line = line_b; o_busy = busy_b; o_done = done_b; o_dec = dec_b; end
            2: begin o_line = line_c; o_busy = busy_c; o_done = done_c; o_dec = dec_c; end
            default: begin o_line = line_d; o_busy = busy_d; o_done = done_d; o_dec = dec_d; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic split(input logic [127:0] din, input int nch, input int dw,
                         output logic [15:0] w [8]);
        logic [127:0] mask;
        mask = (128'd1 << dw) - 128'd1;
        for (int i = 0; i < 8; i++) w[i] = '0;
        for (int i = 0; i < nch; i++) w[i] = 16'((din >> (i * dw)) & mask);
    endtask

    // Reference: list every character bit of the frame, each held cpb cycles.
    task automatic build_frame(input int cpb, input int nch, input int dw, input int par,
                               input logic [15:0] w [8]);
        logic chr[$];
        int   fbit;
        exp_q.delete();
        dec_q.delete();
        fbit = 0;
        for (int c = 0; c < nch; c++) begin
            chr.delete();
            chr.push_back(1'b0);
            for (int i = 0; i < dw; i++) chr.push_back(w[c][i]);
            if (par != 0) chr.push_back(^w[c]);
            chr.push_back(1'b1);
            foreach (chr[j]) begin
                for (int k = 0; k < cpb; k++) begin
                    exp_q.push_back(chr[j]);
                    dec_q.push_back(14'(fbit));
                end
                fbit++;
            end
        end
    endtask

    task automatic check_frame(input string nm, input int cpb, input int nch, input int dw,
                               input int par, input int gap, input logic [15:0] w [8],
                               input bit to_idle);
        int          n;
        logic [0:0]  eb;
        logic [13:0] ed;
        build_frame(cpb, nch, dw, par, w);
        n = 0;
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            ed = dec_q.pop_front();
            @(negedge clk);
            chk($sformatf("%s_line[%0d]", nm, n), 32'(o_line), 32'(eb));
            chk($sformatf("%s_busy[%0d]", nm, n), 32'(o_busy), 32'd1);
            chk($sformatf("%s_dec[%0d]", nm, n), 32'(o_dec), 32'(ed));
            chk($sformatf("%s_done[%0d]", nm, n), 32'(o_done), 32'd0);
            n++;
        end
        @(negedge clk);
        chk($sformatf("%s_done_pulse", nm), 32'(o_done), 32'd1);
        chk($sformatf("%s_gap_busy0", nm), 32'(o_busy), 32'd1);
        chk($sformatf("%s_gap_line0", nm), 32'(o_line), 32'd1);
        chk($sformatf("%s_gap_dec0", nm), 32'(o_dec), 32'd0);
        for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            chk($sformatf("%s_gap_done[%0d]", nm, g), 32'(o_done), 32'd0);
            chk($sformatf("%s_gap_busy[%0d]", nm, g), 32'(o_busy), 32'd1);
            chk($sformatf("%s_gap_line[%0d]", nm, g), 32'(o_line), 32'd1);
            chk($sformatf("%s_gap_dec[%0d]", nm, g), 32'(o_dec), 32'd0);
        end
        if (to_idle) begin
            @(negedge clk);
            chk($sformatf("%s_idle_busy", nm), 32'(o_busy), 32'd0);
            chk($sformatf("%s_idle_line", nm), 32'(o_line), 32'd1);
            chk($sformatf("%s_idle_done", nm), 32'(o_done), 32'd0);
            chk($sformatf("%s_idle_dec", nm), 32'(o_dec), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] w [8];
        checks = 0; failures = 0; sel = 0;
        rst_a = 1'b0; rst_bc = 1'b0; rst_d = 1'b0;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; st_d = 1'b0;
        din_a = 24'h3C81A5; din_b = 8'h01; din_c = '0; din_d = 24'($urandom);

        // Reset state of every instance
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d_line", s), 32'(o_line), 32'd1);
            chk($sformatf("rst%0d_busy", s), 32'(o_busy), 32'd0);
            chk($sformatf("rst%0d_done", s), 32'(o_done), 32'd0);
            chk($sformatf("rst%0d_dec", s), 32'(o_dec), 32'd0);
        end
        @(negedge clk);
        rst_a = 1'b1; rst_bc = 1'b1;
        sel = 0;
        repeat (3) begin
            @(negedge clk);
            chk("a_idle_busy", 32'(o_busy), 32'd0);
            chk("a_idle_line", 32'(o_line), 32'd1);
        end

        // Directed frame x=A5 y=81 z=3C
        split(128'(din_a), 3, 8, w);
        st_a = 1'b1; @(posedge clk); #1 st_a = 1'b0;
        check_frame("a1", 1, 3, 8, 0, 4, w, 1'b1);

        // Random frames; data changes and start pulses mid-frame must not disturb them
        for (int k = 0; k < 3; k++) begin
            din_a = 24'($urandom);
            split(128'(din_a), 3, 8, w);
            st_a = 1'b1; @(posedge clk); #1 st_a = 1'b0;
            fork
                check_frame($sformatf("a2_%0d", k), 1, 3, 8, 0, 4, w, 1'b1);
                begin
                    repeat ($urandom_range(2, 25)) @(posedge clk);
                    #1 din_a = 24'($urandom); st_a = 1'b1;
                    @(posedge clk); #1 st_a = 1'b0;
                end
            join
            repeat (2) begin
                @(negedge clk);
                chk("a2_noqueue_busy", 32'(o_busy), 32'd0);
                chk("a2_noqueue_line", 32'(o_line), 32'd1);
            end
        end

        // Start held high: relaunch on the first idle cycle after the gap
        din_a = 24'($urandom);
        split(128'(din_a), 3, 8, w);
        st_a = 1'b1; @(posedge clk);
        check_frame("a3", 1, 3, 8, 0, 4, w, 1'b1);
        fork
            check_frame("a3b", 1, 3, 8, 0, 4, w, 1'b1);
            begin repeat (3) @(posedge clk); #1 st_a = 1'b0; end
        join

        // Reset mid-frame at bit 12 (y bit 1 = 0 so the line is low before reset)
        din_a = 24'h7E8133;
        st_a = 1'b1; @(posedge clk); #1 st_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("a4_pre_line", 32'(o_line), 32'd0);
        chk("a4_pre_dec", 32'(o_dec), 32'd12);
        #1 rst_a = 1'b0;
        #1;
        chk("a4_rst_line", 32'(o_line), 32'd1);
        chk("a4_rst_busy", 32'(o_busy), 32'd0);
        chk("a4_rst_done", 32'(o_done), 32'd0);
        chk("a4_rst_dec", 32'(o_dec), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("a4_hold_done", 32'(o_done), 32'd0);
            chk("a4_hold_busy", 32'(o_busy), 32'd0);
        end
        rst_a = 1'b1;
        @(negedge clk);
        chk("a4_rel_busy", 32'(o_busy), 32'd0);
        din_a = 24'($urandom);
        split(128'(din_a), 3, 8, w);
        st_a = 1'b1; @(posedge clk); #1 st_a = 1'b0;
        check_frame("a4_restart", 1, 3, 8, 0, 4, w, 1'b1);

        // Three clocks per bit, single channel
        sel = 1;
        for (int k = 0; k < 3; k++) begin
            din_b = (k == 0) ? 8'h01 : 8'($urandom);
            split(128'(din_b), 1, 8, w);
            st_b = 1'b1; @(posedge clk); #1 st_b = 1'b0;
            check_frame($sformatf("b%0d", k), 3, 1, 8, 0, 2, w, 1'b1);
        end

        // Even parity, 7-bit words, two channels, two clocks per bit
        sel = 2;
        for (int k = 0; k < 4; k++) begin
            din_c = (k == 0) ? 14'h0007 : (k == 1) ? 14'h3F80 : 14'($urandom);
            split(128'(din_c), 2, 7, w);
            st_c = 1'b1; @(posedge clk); #1 st_c = 1'b0;
            check_frame($sformatf("c%0d", k), 2, 2, 7, 1, 3, w, 1'b1);
        end

        // Auto-repeat: first start bit on the first edge after reset release
        sel = 3;
        split(128'(din_d), 3, 8, w);
        @(negedge clk);
        rst_d = 1'b1;
        check_frame("d1", 1, 3, 8, 0, 4, w, 1'b0);
        split(128'(din_d), 3, 8, w);
        fork
            check_frame("d2", 1, 3, 8, 0, 4, w, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1 din_d = 24'($urandom); st_d = 1'($urandom);
            end
        join
        split(128'(din_d), 3, 8, w);
        check_frame("d3", 1, 3, 8, 0, 4, w, 1'b0);
        rst_d = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
